// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared constants for the HUB75 scan datapath
package hub75_pkg;
    localparam int COLS         = 64;
    localparam int ROWS         = 32;
    localparam int RGB_W        = 6;
    localparam int DELAY_CYCLES = 256;
    localparam int COL_W        = $clog2(COLS);
    localparam int ROW_W        = $clog2(ROWS);
    localparam int SHIFT_PIPE   = 2;
    localparam int LAT_PIPE     = 3;
    localparam int PLANE_W      = 3;
endpackage

// File: rtl/hub75_delay_timer.sv
// rtl/hub75_delay_timer.sv - loadable down-counter with a one-cycle done pulse
module hub75_delay_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] load,
    output logic         done
);
    logic [W-1:0] count;
    logic         active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            // Done is registered one count early so it lands in the cycle count reaches 0;
            // a restart in that cycle suppresses it.
            done <= active && !start && (count == W'(1));
            if (start) begin
                count  <= load;
                active <= 1'b1;
            end else if (active) begin
                if (count == '0)
                    active <= 1'b0;
                else
                    count <= count - W'(1);
            end
        end
    end
endmodule

// File: rtl/hub75_scan_datapath.sv
// rtl/hub75_scan_datapath.sv - HUB75 counters, delay timer and panel pin registers
// Optional bit-plane (BCM) support enabled by defining HUB75_BCM_EN.
module hub75_scan_datapath #(
    parameter int COLS         = hub75_pkg::COLS,
    parameter int ROWS         = hub75_pkg::ROWS,
    parameter int DELAY_CYCLES = hub75_pkg::DELAY_CYCLES,
    parameter int RGB_W        = hub75_pkg::RGB_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      col_inc,
    input  logic                      row_inc,
    input  logic                      delay_start,
    input  logic                      latch_set,
    input  logic                      latch_clr,
    input  logic                      oe_enable,
    input  logic                      oe_disable,
    output logic                      col_max,
    output logic                      row_max,
    output logic                      delay_done,
`ifdef HUB75_BCM_EN
    output logic [hub75_pkg::PLANE_W+$clog2(ROWS)+$clog2(COLS)-1:0] mem_addr,
    output logic [hub75_pkg::PLANE_W-1:0] mem_plane,
`else
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0] mem_addr,
`endif
    input  logic [RGB_W-1:0]          rgb_in,
    output logic [RGB_W-1:0]          hub_rgb,
    output logic                      hub_clk,
    output logic                      hub_lat,
    output logic                      hub_oe_n,
    output logic [$clog2(ROWS)-1:0]   hub_addr
);
    import hub75_pkg::*;

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
`ifdef HUB75_BCM_EN
    localparam int TW = $clog2(DELAY_CYCLES << ((1 << PLANE_W) - 1));
`else
    localparam int TW = $clog2(DELAY_CYCLES);
`endif

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [SHIFT_PIPE-1:0] shift_pipe;
    logic [LAT_PIPE-1:0]   set_pipe;
    logic [LAT_PIPE-2:0]   clr_pipe;
    logic                  lat_reg;
    logic                  oe_reg;
    logic [TW-1:0]         delay_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            hub_rgb    <= '0;
            shift_pipe <= '0;
            set_pipe   <= '0;
            clr_pipe   <= '0;
            lat_reg    <= 1'b0;
            oe_reg     <= 1'b1;
            hub_addr   <= '0;
        end else begin
            if (col_inc) begin
                col     <= col + CW'(1);
                hub_rgb <= rgb_in;
            end
            if (oe_disable)
                row <= '0;
            else if (row_inc)
                row <= row + RW'(1);

            shift_pipe <= {shift_pipe[SHIFT_PIPE-2:0], col_inc};
            set_pipe   <= {set_pipe[LAT_PIPE-2:0], latch_set};
            clr_pipe   <= {clr_pipe[LAT_PIPE-3:0], latch_clr};

            // The LAT register itself is the last pipe stage, so it samples one stage early.
            if (clr_pipe[LAT_PIPE-2])
                lat_reg <= 1'b0;
            else if (set_pipe[LAT_PIPE-2])
                lat_reg <= 1'b1;
            if (set_pipe[LAT_PIPE-1])
                hub_addr <= row;

            if (oe_disable)
                oe_reg <= 1'b1;
            else if (oe_enable)
                oe_reg <= 1'b0;
        end
    end

    assign col_max  = (col == CW'(COLS - 1));
    assign row_max  = (row == RW'(ROWS - 1));
    assign hub_clk  = shift_pipe[SHIFT_PIPE-1];
    assign hub_lat  = lat_reg;
    assign hub_oe_n = oe_reg | lat_reg;

`ifdef HUB75_BCM_EN
    logic [PLANE_W-1:0] plane;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            plane <= '0;
        else if (oe_disable)
            plane <= plane + PLANE_W'(1);
    end

    assign mem_plane  = plane;
    assign mem_addr   = {plane, row, col};
    assign delay_load = (TW'(DELAY_CYCLES) << plane) - TW'(1);
`else
    assign mem_addr   = {row, col};
    assign delay_load = TW'(DELAY_CYCLES - 1);
`endif

    hub75_delay_timer #(.W(TW)) u_delay_timer (
        .clk   (clk),
        .rst   (rst),
        .start (delay_start),
        .load  (delay_load),
        .done  (delay_done)
    );
endmodule

// File: doc/hub75_scan_datapath.md
Name: hub75_scan_datapath

Overview:
- Datapath companion to the HUB75 scan FSM; consumes its one-cycle strobes (col_inc, row_inc, delay_start, latch_set/clr, oe_enable/disable) and returns col_max, row_max, delay_done.
- Owns the column/row counters, the frame-memory read address, the row-display delay timer and the registered panel pins (CLK, LAT, OE_n, ABCDE, RGB).
- Aligns LAT and OE to the shifted data through a short control pipeline.

Parameters:
- COLS, 64, columns shifted per row; power of two, ≥2
- ROWS, 32, scan rows (ABCDE address space); power of two, ≥2
- DELAY_CYCLES, 256, row display time in clk cycles; ≥2
- RGB_W, 6, pixel bits per shift (R1G1B1R2G2B2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- col_inc, row_inc, delay_start, latch_set, latch_clr, oe_enable, oe_disable  in  1 each  FSM strobes
- col_max  out  1  column counter == COLS-1
- row_max  out  1  row counter == ROWS-1
- delay_done  out  1  one-cycle pulse at end of delay
- mem_addr  out  log2(ROWS)+log2(COLS)  {row, col} read address to frame RAM (1-cycle read latency)
- rgb_in  in  RGB_W  RAM read data
- hub_rgb  out  RGB_W  panel data
- hub_clk  out  1  panel shift clock
- hub_lat  out  1  panel latch
- hub_oe_n  out  1  panel output enable, active-low
- hub_addr  out  log2(ROWS)  panel row select ABCDE

Behaviour:
- Reset (async, rst=0): col=0, row=0, timer idle, all pipes cleared; outputs: col_max=0, row_max=0, delay_done=0, mem_addr=0, hub_rgb=0, hub_clk=0, hub_lat=0, hub_oe_n=1, hub_addr=0. Reset mid-row abandons the row; no partial latch is emitted.
- Column counter: +1 on col_inc; wraps COLS-1 → 0. col_max combinational from the register.
- Row counter: +1 on row_inc; wraps ROWS-1 → 0. oe_disable (frame start) clears it to 0; oe_disable has priority over row_inc. row_max combinational.
- mem_addr = {row, col}, combinational from the counter registers. RAM data for the current column is valid in the cycle col_inc is asserted.
- Shift pipe, with col_inc at cycle N:
  - hub_rgb <= rgb_in at the N edge (valid N+1).
  - Stage-1 flag in N+1.
  - hub_clk high for cycle N+2 only.
  - Data is stable ≥1 cycle before the rising edge of hub_clk.
- Latch pipe: latch_set/latch_clr delayed 3 cycles.
  - hub_lat set on delayed latch_set and cleared on delayed latch_clr, giving one cycle high immediately after the last hub_clk falls.
  - Simultaneous delayed set and clr: clr wins.
- hub_addr <= row counter in the cycle the delayed latch_set fires (row incremented only after the delay, so the latched row is shown).
- OE register: oe_disable → 1, oe_enable → 0; both in one cycle: disable wins.
  - hub_oe_n = oe_reg OR hub_lat, so the panel is blanked during the latch.
- Delay timer, FSM-free down-counter:
  - delay_start loads DELAY_CYCLES-1 and sets active.
  - Decrements while active; at 0 it pulses delay_done for one cycle and goes idle. delay_start at cycle M gives delay_done high in cycle M+DELAY_CYCLES.
  - delay_start while active restarts the count; no done is emitted for the aborted count.
- Counter widths exactly log2(COLS)/log2(ROWS). Overflow only by wrap.

Optional Feature:
- HUB75_BCM_EN defined:
  - Adds a 3-bit bit-plane counter, incremented on each oe_disable and wrapping 7 → 0.
  - Delay load becomes (DELAY_CYCLES << plane) - 1, with a widened timer.
  - Extra output mem_plane[2:0] is appended as the MSBs of mem_addr.
- Undefined: fixed DELAY_CYCLES and no plane logic; mem_addr exactly {row, col}.

Decomposition:
- hub75_pkg: COLS, ROWS, RGB_W, COL_W, ROW_W, SHIFT_PIPE=2, LAT_PIPE=3 constants; BCM plane width constant.
- One sub-module: hub75_delay_timer (load/count/done pulse, width parameter).
- Everything else stays flat.

Test Plan:
- Release reset, hold all strobes 0 for 10 cycles → hub_oe_n=1, hub_lat=0, hub_clk=0, mem_addr=0, delay_done never asserted.
- col_inc every 2nd cycle ×64 with rgb_in=col[5:0] → 64 hub_clk pulses, each preceded by hub_rgb=col; col_max high after the 63rd increment; col wraps to 0 after the 64th.
- latch_set at N, latch_clr at N+1 with row=5 → hub_lat high only in N+3, hub_oe_n=1 in N+3, hub_addr=5 from N+4.
- delay_start at M with DELAY_CYCLES=256 → single delay_done pulse at M+256; a re-start at M+100 → done moves to M+356 and no pulse at M+256.
- row_inc ×31 then oe_disable with row_inc in the same cycle → row_max=1 at row 31, row=0 after oe_disable, hub_oe_n=1.
- HUB75_BCM_EN: 3 frames (oe_disable pulses) → delay lengths 512, 1024, 2048 on successive planes; mem_plane 1, 2, 3.
